// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types, latency constants and helpers for hazard_scoreboard
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int C_LAT_ALU    = 3;
    localparam int C_LAT_MEM    = 4;
    localparam int C_LAT_MULDIV = 6;
    localparam int C_KILL_DEPTH = 2;
    localparam int C_DEPTH      = 8;
    localparam int C_AGE_W      = 4;

    typedef enum logic [1:0] {
        LC_ALU    = 2'd0,
        LC_MEM    = 2'd1,
        LC_MULDIV = 2'd2
    } lat_class_e;

    typedef struct packed {
        logic               valid;
        logic [4:0]         rd;
        lat_class_e         lclass;
        logic [C_AGE_W-1:0] age;
    } sb_entry_t;

    function automatic int lat_of(input lat_class_e lc,
                                  input int lat_alu    = C_LAT_ALU,
                                  input int lat_mem    = C_LAT_MEM,
                                  input int lat_muldiv = C_LAT_MULDIV);
        case (lc)
            LC_MEM:    return lat_mem;
            LC_MULDIV: return lat_muldiv;
            default:   return lat_alu;
        endcase
    endfunction

    // Encoding 3 is not a real class; it is executed as an ALU op.
    function automatic lat_class_e norm_class(input logic [1:0] raw);
        return (raw == 2'd3) ? LC_ALU : lat_class_e'(raw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_entry.sv
// ============================================================================
//  Module   : sb_entry
//  Purpose  : One scoreboard slot: ages, retires and squashes a tracked write
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sb_entry
    import hazard_pkg::*;
#(
    parameter int LAT_ALU    = C_LAT_ALU,
    parameter int LAT_MEM    = C_LAT_MEM,
    parameter int LAT_MULDIV = C_LAT_MULDIV,
    parameter int KILL_DEPTH = C_KILL_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       squash_i,
    input  logic       insert_i,
    input  logic [4:0] rd_i,
    input  lat_class_e lclass_i,
    output sb_entry_t  entry_o
);

    localparam logic [C_AGE_W-1:0] AGE_ONE = C_AGE_W'(1);

    sb_entry_t entry_q;
    sb_entry_t entry_d;
    int        lat_w;
    int        age_n;

    always_comb begin
        entry_d = entry_q;
        lat_w   = lat_of(entry_q.lclass, LAT_ALU, LAT_MEM, LAT_MULDIV);
        age_n   = 32'(entry_q.age);
        if (entry_q.valid) begin
            entry_d.age = entry_q.age + AGE_ONE;
            // Slot is freed once the write is visible to readers (age W-1).
            if (age_n + 1 >= lat_w - 1) begin
                entry_d.valid = 1'b0;
            end
            if (squash_i && (age_n < KILL_DEPTH)) begin
                entry_d.valid = 1'b0;
            end
        end
        if (insert_i) begin
            entry_d.valid  = 1'b1;
            entry_d.rd     = rd_i;
            entry_d.lclass = lclass_i;
            entry_d.age    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : RAW/WAW/mul-div hazard stall and branch flush for the 7-stage core
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LAT_ALU    = C_LAT_ALU,
    parameter int LAT_MEM    = C_LAT_MEM,
    parameter int LAT_MULDIV = C_LAT_MULDIV,
    parameter int KILL_DEPTH = C_KILL_DEPTH,
    parameter int DEPTH      = C_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  rd,
    input  logic        we,
    input  logic [1:0]  lat_class,
    input  logic        bjtaken,
    output logic        stall,
    output logic        flush,
    output logic        muldiv_busy,
    output logic [31:0] pending
);

    sb_entry_t        ent [DEPTH];
    logic [DEPTH-1:0] slot_sel;
    logic [DEPTH-1:0] slot_ins;
    logic             found;
    logic             insert;
    lat_class_e       new_lc;
    int               w_new;
    int               w_e;
    int               age_e;
    logic [31:0]      pend_vec;
    logic             busy;
    logic             raw;
    logic             waw;
    logic             structural;

    always_comb begin
        pend_vec   = '0;
        busy       = 1'b0;
        waw        = 1'b0;
        w_e        = 0;
        age_e      = 0;
        new_lc     = norm_class(lat_class);
        w_new      = lat_of(new_lc, LAT_ALU, LAT_MEM, LAT_MULDIV);
        for (int i = 0; i < DEPTH; i++) begin
            w_e   = lat_of(ent[i].lclass, LAT_ALU, LAT_MEM, LAT_MULDIV);
            age_e = 32'(ent[i].age);
            if (ent[i].valid) begin
                if (age_e < w_e - 1) begin
                    pend_vec[ent[i].rd] = 1'b1;
                end
                if ((ent[i].lclass == LC_MULDIV) && (age_e < LAT_MULDIV - 1)) begin
                    busy = 1'b1;
                end
                // An older write that would land at or after the new one blocks it.
                if (we && (rd != 5'd0) && (ent[i].rd == rd) && (w_e - 1 - age_e >= w_new)) begin
                    waw = 1'b1;
                end
            end
        end
        pend_vec[0] = 1'b0;
        raw = (rs1_used && (rs1 != 5'd0) && pend_vec[rs1]) ||
              (rs2_used && (rs2 != 5'd0) && pend_vec[rs2]);
        structural  = (lat_class == 2'd2) && busy;
        stall       = issue_valid && !bjtaken && (raw || waw || structural);
        flush       = bjtaken;
        muldiv_busy = busy;
        pending     = pend_vec;
        insert      = issue_valid && !stall && !bjtaken && we && (rd != 5'd0);
    end

    always_comb begin
        found    = 1'b0;
        slot_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && !ent[i].valid) begin
                found       = 1'b1;
                slot_sel[i] = 1'b1;
            end
        end
        slot_ins = slot_sel & {DEPTH{insert}};
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_slot
            sb_entry #(
                .LAT_ALU    (LAT_ALU),
                .LAT_MEM    (LAT_MEM),
                .LAT_MULDIV (LAT_MULDIV),
                .KILL_DEPTH (KILL_DEPTH)
            ) u_entry (
                .clk      (clk),
                .rst      (rst),
                .squash_i (bjtaken),
                .insert_i (slot_ins[g]),
                .rd_i     (rd),
                .lclass_i (new_lc),
                .entry_o  (ent[g])
            );
        end
    endgenerate

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) insert |-> found);

endmodule

`default_nettype wire
